// File: rtl/answer_judge_pkg.sv
// Shared types and constants for the answer judge: FSM encoding, target LFSR taps, build defaults.
package answer_judge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Feedback taps l[7]^l[5]^l[4]^l[3]
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam int         KEY_W_DEF     = 4;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/answer_judge_key_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detect for asynchronous push-buttons.
// o_ks lags the raw input by 2 clocks; o_rise is registered and lags it by 3.
module key_sync_edge #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_ks,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_ks;
    logic [W-1:0] r_ks_d;
    logic [W-1:0] r_rise;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_ks   <= '0;
            r_ks_d <= '0;
            r_rise <= '0;
        end else begin
            r_meta <= i_d;
            r_ks   <= r_meta;
            r_ks_d <= r_ks;
            r_rise <= r_ks & ~r_ks_d;
        end
    end

    assign o_ks   = r_ks;
    assign o_rise = r_rise;

endmodule

// File: rtl/answer_judge.sv
// Picks a pseudo-random one-hot target per round and judges the player's key press or timeout.
// correct/wrong are registered one-cycle pulses, 3 clocks after a raw press is first sampled.
module answer_judge
    import answer_judge_pkg::*;
#(
    parameter int         KEY_W         = KEY_W_DEF,
    parameter logic [7:0] LFSR_SEED     = LFSR_SEED_DEF,
    parameter int         TIMEOUT_TICKS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             game_on,
    input  logic             tick,
    input  logic [KEY_W-1:0] keys,
    output logic [KEY_W-1:0] target,
    output logic             correct,
    output logic             wrong,
    output logic [1:0]       state
);

    localparam int               CNT_W     = $clog2(TIMEOUT_TICKS) + 1;
    localparam logic [7:0]       SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TIMEOUT_TICKS - 1);

    logic [KEY_W-1:0] w_ks;
    logic [KEY_W-1:0] w_rise;
    logic [7:0]       w_lfsr_next;
    logic [KEY_W-1:0] w_target_next;

    state_t           r_state;
    logic [7:0]       r_lfsr;
    logic [KEY_W-1:0] r_target;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             r_correct;
    logic             r_wrong;

    key_sync_edge #(.W(KEY_W)) u_key_sync (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_d     (keys),
        .o_ks    (w_ks),
        .o_rise  (w_rise)
    );

    assign w_lfsr_next   = lfsr_step(r_lfsr);
    assign w_target_next = KEY_W'(1) << w_lfsr_next[1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_lfsr     <= SEED_EFF;
            r_target   <= '0;
            r_tick_cnt <= '0;
            r_correct  <= 1'b0;
            r_wrong    <= 1'b0;
        end else begin
            r_correct <= 1'b0;
            r_wrong   <= 1'b0;
            // Leaving the game overrides everything, including a press judged this cycle
            if (!game_on) begin
                r_state  <= IDLE;
                r_target <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_target <= '0;
                        r_state  <= ARM;
                    end
                    ARM: begin
                        r_lfsr     <= w_lfsr_next;
                        r_target   <= w_target_next;
                        r_tick_cnt <= '0;
                        r_state    <= WAIT;
                    end
                    WAIT: begin
                        if (w_rise != '0) begin
                            if (w_ks == r_target) r_correct <= 1'b1;
                            else                  r_wrong   <= 1'b1;
                            r_state <= HOLD;
                        end else if (tick) begin
                            if (r_tick_cnt == LAST_TICK) begin
                                r_wrong <= 1'b1;
                                r_state <= ARM;
                            end else begin
                                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (w_ks == '0) r_state <= ARM;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign target  = r_target;
    assign correct = r_correct;
    assign wrong   = r_wrong;
    assign state   = r_state;

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: reset, target sequence, latency, wrong keys, timeout, races.
module tb_answer_judge;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       game_on = 1'b0;
    logic       tick    = 1'b0;
    logic [3:0] keys    = 4'b0000;
    logic [3:0] target;
    logic       correct;
    logic       wrong;
    logic [1:0] state;

    int total    = 0;
    int bad      = 0;
    int both_cnt = 0;
    int n_cor    = 0;
    int n_wr     = 0;
    int nz       = 0;

    answer_judge dut (
        .clock   (clock),
        .reset   (reset),
        .game_on (game_on),
        .tick    (tick),
        .keys    (keys),
        .target  (target),
        .correct (correct),
        .wrong   (wrong),
        .state   (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (correct && wrong) both_cnt++;
        if (correct) n_cor++;
        if (wrong)   n_wr++;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
        int i = 0;
        while (state !== s && i < budget) begin
            step();
            i++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        n_cor = 0;
        n_wr  = 0;
        keys  = k;
        repeat (hold) step();
        keys = 4'b0000;
        wait_state("release_rearm", 2'd2, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        reset = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        repeat (20) begin
            step();
            if (state != 2'd0 || target != 4'd0 || correct || wrong) nz++;
        end
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_target", 32'(target), 32'd0);
        chk("rst_pulses", 32'({correct, wrong}), 32'd0);
        chk("idle_stable", 32'(nz), 32'd0);

        // First round: A5 -> 4A, target 0100
        game_on = 1'b1;
        step();
        chk("arm_state", 32'(state), 32'd1);
        chk("arm_target", 32'(target), 32'd0);
        step();
        chk("wait_state", 32'(state), 32'd2);
        chk("target_4A", 32'(target), 32'b0100);

        // Correct press held 10 cycles: one pulse, 3 edges after first sample
        n_cor = 0;
        n_wr  = 0;
        keys  = 4'b0100;
        repeat (3) step();
        chk("lat_early", 32'(n_cor), 32'd0);
        step();
        chk("lat_correct", 32'(correct), 32'd1);
        chk("lat_wrong", 32'(wrong), 32'd0);
        repeat (6) step();
        chk("one_correct", 32'(n_cor), 32'd1);
        chk("no_wrong", 32'(n_wr), 32'd0);
        chk("hold_state", 32'(state), 32'd3);
        keys = 4'b0000;
        wait_state("rearm_after_hold", 2'd2, 10);
        chk("target_95", 32'(target), 32'b0010);

        // Wrong single key, then two keys at once
        press(4'b0001, 6);
        chk("wrongkey_wr", 32'(n_wr), 32'd1);
        chk("wrongkey_cor", 32'(n_cor), 32'd0);
        chk("target_2A", 32'(target), 32'b0100);
        press(4'b0101, 6);
        chk("multikey_wr", 32'(n_wr), 32'd1);
        chk("multikey_cor", 32'(n_cor), 32'd0);
        chk("target_54", 32'(target), 32'b0001);

        // Timeout on the third tick
        n_cor = 0;
        n_wr  = 0;
        repeat (2) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (3) step();
        end
        chk("to_early", 32'(n_wr), 32'd0);
        chk("to_still_wait", 32'(state), 32'd2);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("to_wrong", 32'(wrong), 32'd1);
        chk("to_arm", 32'(state), 32'd1);
        step();
        chk("to_rewait", 32'(state), 32'd2);
        chk("to_once", 32'(n_wr), 32'd1);
        chk("to_cor", 32'(n_cor), 32'd0);
        chk("target_A9", 32'(target), 32'b0010);

        // Press judged in the same cycle as the final tick: press wins
        repeat (2) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (3) step();
        end
        n_cor = 0;
        n_wr  = 0;
        keys  = 4'b0010;
        repeat (3) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("race_correct", 32'(correct), 32'd1);
        chk("race_wrong", 32'(wrong), 32'd0);
        chk("race_hold", 32'(state), 32'd3);
        keys = 4'b0000;
        wait_state("race_rearm", 2'd2, 10);
        chk("race_nwr", 32'(n_wr), 32'd0);
        chk("target_53", 32'(target), 32'b1000);

        // game_on drops exactly when the press is judged
        n_cor = 0;
        n_wr  = 0;
        keys  = 4'b1000;
        repeat (3) step();
        game_on = 1'b0;
        step();
        chk("drop_pulses", 32'({correct, wrong}), 32'd0);
        chk("drop_state", 32'(state), 32'd0);
        chk("drop_target", 32'(target), 32'd0);
        keys = 4'b0000;
        repeat (5) step();
        chk("drop_quiet", 32'(n_cor + n_wr), 32'd0);
        game_on = 1'b1;
        wait_state("regame_wait", 2'd2, 10);
        chk("target_A7", 32'(target), 32'b1000);

        // Reset mid-HOLD restarts the LFSR from its seed
        keys = 4'b1000;
        repeat (4) step();
        chk("prerst_correct", 32'(correct), 32'd1);
        step();
        chk("prerst_hold", 32'(state), 32'd3);
        reset = 1'b0;
        keys  = 4'b0000;
        step();
        chk("rst_hold_state", 32'(state), 32'd0);
        chk("rst_hold_target", 32'(target), 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("postrst_arm", 32'(state), 32'd1);
        step();
        chk("postrst_wait", 32'(state), 32'd2);
        chk("postrst_target", 32'(target), 32'b0100);

        chk("never_both", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
